// File: rtl/iir_pkg.sv
// Shared types and constants for the IIR tap accumulator: FSM states,
// datapath widths, saturation limits and the saturating 64-bit add.
package iir_pkg;

   typedef enum logic [1:0] {
      COLLECT,
      ROUND,
      OUT
   } state_t;

   localparam int PROD_W  = 64;
   localparam int WHOLE_W = 15;
   localparam int Y_MAX   = 32767;

   localparam logic signed [PROD_W-1:0] ACC_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [PROD_W-1:0] ACC_MIN = 64'sh8000_0000_0000_0000;

   typedef struct packed {
      logic signed [PROD_W-1:0] sum;
      logic                     ovf;
   } sat_sum_t;

   // Overflow only happens when both operands share a sign and the result flips it.
   function automatic sat_sum_t satAdd(input logic signed [PROD_W-1:0] a,
                                       input logic signed [PROD_W-1:0] b);
      sat_sum_t res;
      res.sum = a + b;
      res.ovf = (a[PROD_W-1] == b[PROD_W-1]) && (res.sum[PROD_W-1] != a[PROD_W-1]);
      if (res.ovf) begin
         res.sum = b[PROD_W-1] ? ACC_MIN : ACC_MAX;
      end
      return res;
   endfunction

endpackage

// File: rtl/iir_tap_accumulator_if.sv
// Product-in / sample-out handshake bundle between the multiplier, the
// tap accumulator and whatever consumes the rescaled sample.
interface iir_tap_accumulator_if;
   import iir_pkg::*;

   logic signed [PROD_W-1:0]  prod;
   logic                      prodOvf;
   logic                      in_valid;
   logic                      in_ready;
   logic        [WHOLE_W-1:0] yWhole;
   logic                      ySign;
   logic                      ovf;
   logic                      out_valid;
   logic                      out_ready;

   modport master (
      output prod, prodOvf, in_valid, out_ready,
      input  in_ready, yWhole, ySign, ovf, out_valid
   );

   modport slave (
      input  prod, prodOvf, in_valid, out_ready,
      output in_ready, yWhole, ySign, ovf, out_valid
   );

endinterface

// File: rtl/iir_tap_accumulator_round_saturate.sv
// Combinational round-half-up, Q-format rescale and clamp of the 64-bit sum
// into the 15-bit sign-magnitude operand format the multiplier consumes.
module round_saturate
   import iir_pkg::*;
#(
   parameter int FRAC = 14
) (
   input  logic signed [PROD_W-1:0]  i_acc,
   input  logic                      i_sticky,
   output logic        [WHOLE_W-1:0] o_yWhole,
   output logic                      o_ySign,
   output logic                      o_ovf
);

   localparam logic signed [PROD_W:0] HALF  = 65'sd1 <<< (FRAC - 1);
   localparam logic signed [PROD_W:0] R_MAX = 65'(Y_MAX);
   localparam logic signed [PROD_W:0] R_MIN = -R_MAX;

   logic signed [PROD_W:0]  w_biased;
   logic signed [PROD_W:0]  w_shifted;
   logic signed [WHOLE_W:0] w_clamped;
   logic                    w_clip;

   // One extra bit of headroom lets the rounding bias never wrap; the clamp
   // is symmetric so the magnitude always fits in WHOLE_W bits.
   always_comb begin
      w_biased  = $signed({i_acc[PROD_W-1], i_acc}) + HALF;
      w_shifted = w_biased >>> FRAC;
      w_clip    = 1'b0;
      w_clamped = w_shifted[WHOLE_W:0];
      if (w_shifted > R_MAX) begin
         w_clamped = R_MAX[WHOLE_W:0];
         w_clip    = 1'b1;
      end else if (w_shifted < R_MIN) begin
         w_clamped = R_MIN[WHOLE_W:0];
         w_clip    = 1'b1;
      end
      o_ySign  = w_clamped[WHOLE_W];
      o_yWhole = o_ySign ? WHOLE_W'(-w_clamped) : w_clamped[WHOLE_W-1:0];
      o_ovf    = i_sticky | w_clip;
   end

endmodule

// File: rtl/iir_tap_accumulator.sv
// Sums TAPS signed products into a saturating accumulator, then presents the
// rounded, rescaled result as a registered sign-magnitude sample.
module iir_tap_accumulator
   import iir_pkg::*;
#(
   parameter int TAPS = 5,
   parameter int FRAC = 14
) (
   input logic                  clk,
   input logic                  reset,
   iir_tap_accumulator_if.slave bus
);

   localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

   state_t                    r_state;
   logic signed [PROD_W-1:0]  r_acc;
   logic        [CNT_W-1:0]   r_cnt;
   logic                      r_sticky;
   logic                      r_inReady;
   logic        [WHOLE_W-1:0] r_yWhole;
   logic                      r_ySign;
   logic                      r_ovf;
   logic                      r_outValid;

   sat_sum_t                  w_add;
   logic        [WHOLE_W-1:0] w_yWhole;
   logic                      w_ySign;
   logic                      w_ovf;

   assign w_add = satAdd(r_acc, bus.prod);

   round_saturate #(
      .FRAC (FRAC)
   ) u_round (
      .i_acc    (r_acc),
      .i_sticky (r_sticky),
      .o_yWhole (w_yWhole),
      .o_ySign  (w_ySign),
      .o_ovf    (w_ovf)
   );

   // in_ready is registered from the next state so it never depends
   // combinationally on in_valid or out_ready, and stays low during reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= COLLECT;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_sticky   <= 1'b0;
         r_inReady  <= 1'b0;
         r_yWhole   <= '0;
         r_ySign    <= 1'b0;
         r_ovf      <= 1'b0;
         r_outValid <= 1'b0;
      end else begin
         case (r_state)
            COLLECT: begin
               r_inReady <= 1'b1;
               if (bus.in_valid && r_inReady) begin
                  r_acc    <= w_add.sum;
                  r_sticky <= r_sticky | bus.prodOvf | w_add.ovf;
                  if (r_cnt == LAST_TAP) begin
                     r_cnt     <= '0;
                     r_state   <= ROUND;
                     r_inReady <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ROUND: begin
               r_yWhole   <= w_yWhole;
               r_ySign    <= w_ySign;
               r_ovf      <= w_ovf;
               r_outValid <= 1'b1;
               r_inReady  <= 1'b0;
               r_state    <= OUT;
            end
            OUT: begin
               if (bus.out_ready) begin
                  r_outValid <= 1'b0;
                  r_acc      <= '0;
                  r_sticky   <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_state    <= COLLECT;
               end
            end
            default: begin
               r_state   <= COLLECT;
               r_inReady <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_inReady;
   assign bus.yWhole    = r_yWhole;
   assign bus.ySign     = r_ySign;
   assign bus.ovf       = r_ovf;
   assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_iir_tap_accumulator.sv
// Self-checking bench for iir_tap_accumulator (TAPS=3, FRAC=14): directed
// table vectors, randomized frames against a wide-arithmetic model, and
// backpressure / mid-frame reset sequences.
module tb_iir_tap_accumulator;
   import iir_pkg::*;

   localparam int TAPS = 3;
   localparam int FRAC = 14;
   localparam logic signed [65:0] M_MAX = (66'sd1 <<< 63) - 66'sd1;
   localparam logic signed [65:0] M_MIN = -(66'sd1 <<< 63);

   typedef struct {
      logic [TAPS-1:0][63:0] p;
      logic [TAPS-1:0]       o;
      int                    yw;
      bit                    ys;
      bit                    ov;
      string                 name;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   iir_tap_accumulator_if bus ();

   iir_tap_accumulator #(
      .TAPS (TAPS),
      .FRAC (FRAC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic checkVal(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Reference: exact 66-bit running sum clamped to the 64-bit range after
   // each tap, then floor((sum + half) / 2^FRAC) clamped to +-Y_MAX.
   function automatic void model(input logic [TAPS-1:0][63:0] p, input logic [TAPS-1:0] o,
                                 output int yw, output bit ys, output bit ov);
      logic signed [65:0] a, pe, r;
      bit st, clip;
      a = '0; st = 1'b0; clip = 1'b0;
      for (int i = 0; i < TAPS; i++) begin
         pe = $signed(p[i]);
         a  = a + pe;
         if (a > M_MAX) begin a = M_MAX; st = 1'b1; end
         else if (a < M_MIN) begin a = M_MIN; st = 1'b1; end
         if (o[i]) st = 1'b1;
      end
      r = (a + (66'sd1 <<< (FRAC - 1))) >>> FRAC;
      if (r > 66'sd32767) begin r = 66'sd32767; clip = 1'b1; end
      else if (r < -66'sd32767) begin r = -66'sd32767; clip = 1'b1; end
      ys = (r < 0);
      yw = ys ? int'(-r) : int'(r);
      ov = st | clip;
   endfunction

   function automatic vec_t mk(input string name, input longint a, input longint b, input longint c,
                               input logic [TAPS-1:0] o, input int yw, input bit ys, input bit ov);
      vec_t v;
      v.name = name;
      v.p[0] = a; v.p[1] = b; v.p[2] = c;
      v.o = o; v.yw = yw; v.ys = ys; v.ov = ov;
      return v;
   endfunction

   // Feeds n beats, each on the first edge where in_ready is high.
   task automatic applyStimulus(input logic [TAPS-1:0][63:0] p, input logic [TAPS-1:0] o, input int n);
      int guard;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         guard = 0;
         while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 20) begin
            checkVal("in_ready timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
         end
         bus.prod     = p[i];
         bus.prodOvf  = o[i];
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.prodOvf  = 1'b0;
   endtask

   task automatic waitOut(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 20);
   endtask

   task automatic compareOut(input string tag, input int yw, input bit ys, input bit ov);
      checkVal({tag, " yWhole"}, longint'(bus.yWhole), yw);
      checkVal({tag, " ySign"},  longint'(bus.ySign),  longint'(ys));
      checkVal({tag, " ovf"},    longint'(bus.ovf),    longint'(ov));
   endtask

   task automatic doHandshake(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      checkVal({tag, " out_valid after hs"}, longint'(bus.out_valid), 0);
      checkVal({tag, " in_ready after hs"},  longint'(bus.in_ready),  1);
   endtask

   task automatic checkOutput(input string tag, input int yw, input bit ys, input bit ov);
      int lat;
      waitOut(lat);
      checkVal({tag, " latency"}, lat, 2);
      compareOut(tag, yw, ys, ov);
      doHandshake(tag);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkVal({tag, " out_valid"}, longint'(bus.out_valid), 0);
      checkVal({tag, " in_ready"},  longint'(bus.in_ready),  0);
      compareOut(tag, 0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [TAPS-1:0][63:0] p;
      logic [TAPS-1:0]       o;
      logic [63:0]           v;
      int yw, lat;
      bit ys, ov;
      int unsigned mode;

      reset         = 1'b1;
      bus.prod      = '0;
      bus.prodOvf   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      tbl.push_back(mk("basic",      16384, 16384, -8192, 3'b000, 2, 1'b0, 1'b0));
      tbl.push_back(mk("neg",        -16384, -16384, -16384, 3'b000, 3, 1'b1, 1'b0));
      tbl.push_back(mk("negzero",    -8192, 0, 0, 3'b000, 0, 1'b0, 1'b0));
      tbl.push_back(mk("clip",       longint'(1) <<< 40, longint'(1) <<< 40, longint'(1) <<< 40,
                       3'b000, 32767, 1'b0, 1'b1));
      tbl.push_back(mk("upovf",      16384, 0, 0, 3'b010, 1, 1'b0, 1'b1));
      tbl.push_back(mk("satpos",     longint'(1) <<< 62, longint'(1) <<< 62, 0, 3'b000, 32767, 1'b0, 1'b1));
      tbl.push_back(mk("stickyclr",  16384, 0, 0, 3'b000, 1, 1'b0, 1'b0));
      tbl.push_back(mk("satneg",     -(longint'(1) <<< 62), -(longint'(1) <<< 62), -1,
                       3'b000, 32767, 1'b1, 1'b1));
      tbl.push_back(mk("tieup",      8192, 0, 0, 3'b000, 1, 1'b0, 1'b0));
      tbl.push_back(mk("tieneg",     -24576, 0, 0, 3'b000, 1, 1'b1, 1'b0));
      tbl.push_back(mk("edgemax",    longint'(32767) <<< 14, 0, 0, 3'b000, 32767, 1'b0, 1'b0));
      tbl.push_back(mk("edgemin",    -(longint'(32768) <<< 14), 0, 0, 3'b000, 32767, 1'b1, 1'b1));

      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      reset = 1'b0;
      @(negedge clk);
      checkVal("in_ready after reset", longint'(bus.in_ready), 1);

      foreach (tbl[k]) begin
         applyStimulus(tbl[k].p, tbl[k].o, TAPS);
         checkOutput(tbl[k].name, tbl[k].yw, tbl[k].ys, tbl[k].ov);
      end

      for (int f = 0; f < 25; f++) begin
         for (int i = 0; i < TAPS; i++) begin
            v    = {$urandom, $urandom};
            mode = $urandom_range(0, 3);
            case (mode)
               0:       p[i] = 64'($signed(v[19:0]));
               1:       p[i] = 64'($signed(v[35:0]));
               2:       p[i] = v;
               default: p[i] = v[0] ? (64'sd1 <<< 62) : -(64'sd1 <<< 62);
            endcase
            o[i] = ($urandom_range(0, 7) == 0);
         end
         model(p, o, yw, ys, ov);
         applyStimulus(p, o, TAPS);
         checkOutput($sformatf("rand%0d", f), yw, ys, ov);
      end

      p[0] = 16384; p[1] = 16384; p[2] = 16384; o = '0;
      applyStimulus(p, o, TAPS);
      waitOut(lat);
      checkVal("bp latency", lat, 2);
      bus.prod     = 64'sd1 <<< 40;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         compareOut($sformatf("bp hold%0d", c), 3, 1'b0, 1'b0);
         checkVal($sformatf("bp hold%0d out_valid", c), longint'(bus.out_valid), 1);
         checkVal($sformatf("bp hold%0d in_ready", c),  longint'(bus.in_ready),  0);
      end
      bus.in_valid = 1'b0;
      doHandshake("bp");
      p[0] = 16384; p[1] = 0; p[2] = 0;
      applyStimulus(p, o, TAPS);
      checkOutput("bp next", 1, 1'b0, 1'b0);

      p[0] = 64'sd1 <<< 40; p[1] = 64'sd1 <<< 40; p[2] = 0; o = 3'b011;
      applyStimulus(p, o, 2);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkResetOutputs("midreset");
      end
      reset = 1'b0;
      @(negedge clk);
      checkVal("midreset in_ready", longint'(bus.in_ready), 1);
      p[0] = 16384; p[1] = 16384; p[2] = 16384; o = '0;
      applyStimulus(p, o, TAPS);
      checkOutput("midreset frame", 3, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iir_tap_accumulator.md
# iir_tap_accumulator

Downstream consumer of the sign-magnitude multiplication unit in the IIR datapath. It accepts one 64-bit two's-complement product per tap over a valid/ready handshake and sums TAPS products into a saturating accumulator. After the last tap it rounds and rescales the sum, then presents it as a 15-bit magnitude plus sign: the same operand format the multiplier consumes, so the result can be fed back as the next sample.

## Interface
Parameters:
- TAPS, default 5: products summed per output sample, ≥1.
- FRAC, default 14: fractional bits removed at output (Q-format shift), 1..62.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- prod, in, 64: product, two's complement, already sign-extended.
- prodOvf, in, 1: overflow flag from the multiplier for this product.
- in_valid, in, 1: prod/prodOvf valid.
- in_ready, out, 1: block accepts a product this cycle.
- yWhole, out, 15: output magnitude.
- ySign, out, 1: output sign (1 = negative).
- ovf, out, 1: sample is unreliable (saturated or upstream overflow).
- out_valid, out, 1: yWhole/ySign/ovf valid.
- out_ready, in, 1: consumer takes the result.

## Operation
- FSM states: COLLECT, ROUND, OUT.
- COLLECT:
  - in_ready=1.
  - Each in_valid&&in_ready beat adds prod into acc (64-bit signed), ORs prodOvf into sticky, and increments cnt.
  - The beat with cnt==TAPS-1 moves the FSM to ROUND and clears cnt.
- Accumulator add:
  - Signed overflow (operands same sign, result sign differs) saturates acc to +2^63-1 or -2^63, matching the operand sign, and sets sticky.
  - Once saturated, acc keeps accumulating normally from the clamped value.
- ROUND (one cycle, in_ready=0), handled by round_saturate:
  - r = (acc + 2^(FRAC-1)) >>> FRAC, computed 65-bit so the add cannot wrap. This is round-half-up (toward +∞).
  - Clamp r to [-32767, +32767]; clipping sets the output ovf.
  - yWhole=|r|, ySign=(r<0). A zero result always gives ySign=0 (no negative zero).
  - ovf = sticky | clip.
  - Outputs are registered; the FSM moves to OUT.
- OUT:
  - out_valid=1, in_ready=0. Outputs are held stable until out_valid&&out_ready.
  - On that handshake: acc←0, sticky←0, the FSM moves to COLLECT, out_valid falls next cycle.
- in_valid during ROUND/OUT is ignored and no beat is consumed.

## Timing
- Reset values:
  - State COLLECT; acc, cnt, sticky = 0.
  - yWhole=0, ySign=0, ovf=0, out_valid=0.
  - in_ready=0 while reset is high, 1 in the first cycle after.
- Latency: last tap accepted in cycle n → ROUND in cycle n+1 → out_valid=1 in cycle n+2.
- Best-case throughput: one sample per TAPS+2 cycles; this requires out_ready high during OUT.
- in_ready is a pure function of state, with no combinational path from in_valid or out_ready.
- yWhole/ySign/ovf change only on the ROUND→OUT edge and at reset.
- Reset mid-frame, in any state: partial sum, cnt and pending output are discarded; the next frame starts from 0.
- TAPS=1: every accepted beat goes directly to ROUND.

## Structure
- Shared package iir_pkg holds:
  - State enum (COLLECT, ROUND, OUT).
  - PROD_W=64, WHOLE_W=15.
  - ACC_MAX/ACC_MIN (±2^63 limits).
  - Y_MAX=32767.
- Sub-module round_saturate (combinational): acc[63:0], sticky in; yWhole, ySign, ovf out; parameter FRAC. It is instantiated once, and its outputs are registered in the parent on entry to OUT.
- Parent owns the FSM, cnt, acc, sticky and the handshakes.

## Test plan
1. TAPS=3, FRAC=14; prod 16384, 16384, -8192 → acc 24576. Expected yWhole=2, ySign=0, ovf=0, with out_valid exactly 2 cycles after the third accept.
2. TAPS=3; prod -16384 ×3 → yWhole=3, ySign=1, ovf=0. Variant with a single -8192 plus zeros → yWhole=0, ySign=0.
3. TAPS=3; prod 2^40 ×3 → yWhole=32767, ySign=0, ovf=1. Variant with prodOvf=1 on one small beat (prod 16384, others 0) → yWhole=1, ovf=1.
4. TAPS=2; prod 2^62, 2^62 → acc saturates to 2^63-1. Expected yWhole=32767, ovf=1; after the handshake the next frame (16384, 0) gives yWhole=1, ovf=0, confirming sticky cleared.
5. Backpressure: hold out_ready=0 for 5 cycles in OUT while in_valid=1. Expected: outputs stable, in_ready=0, no beat consumed; after the handshake in_ready=1 the next cycle and the new frame excludes the old sum.
6. Assert reset after 2 of 3 taps, then feed 16384 ×3. Expected yWhole=3 with no contribution from the earlier taps, and all outputs at reset values while reset is held.
